// File: rtl/rename_unit.sv
// Register rename stage: RAT plus circular free list, valid/ready on both sides, commit-side free port.
// Optional macro RENAME_FREE_BYPASS_EN: an empty free list may hand a same-cycle retired preg straight to allocation.
module rename_unit #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64,
  parameter int FL_DEPTH  = NUM_PREGS - NUM_AREGS,
  localparam int AREG_W   = $clog2(NUM_AREGS),
  localparam int PREG_W   = $clog2(NUM_PREGS),
  localparam int CNT_W    = $clog2(FL_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AREG_W-1:0] in_sr1,
  input  logic [AREG_W-1:0] in_sr2,
  input  logic [AREG_W-1:0] in_dr,
  input  logic              in_has_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_sr1_p,
  output logic [PREG_W-1:0] out_sr2_p,
  output logic [PREG_W-1:0] out_dr_p,
  output logic [PREG_W-1:0] out_old_dr_p,
  output logic              out_has_dest,
  input  logic              ret_valid,
  input  logic [PREG_W-1:0] ret_preg,
  output logic [CNT_W-1:0]  free_count
);

  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  logic [PREG_W-1:0] rat_q   [NUM_AREGS];
  logic [PREG_W-1:0] rat_d   [NUM_AREGS];
  logic [PREG_W-1:0] rat_rst [NUM_AREGS];
  logic [PREG_W-1:0] fl_q    [FL_DEPTH];
  logic [PREG_W-1:0] fl_d    [FL_DEPTH];
  logic [PREG_W-1:0] fl_rst  [FL_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [PREG_W-1:0] out_sr1_p_q, out_sr1_p_d;
  logic [PREG_W-1:0] out_sr2_p_q, out_sr2_p_d;
  logic [PREG_W-1:0] out_dr_p_q, out_dr_p_d;
  logic [PREG_W-1:0] out_old_dr_p_q, out_old_dr_p_d;
  logic              out_has_dest_q, out_has_dest_d;

  logic              need_alloc;
  logic              fl_empty;
  logic              fl_full;
  logic              bypass_ok;
  logic              accept;
  logic              take_bypass;
  logic              pop;
  logic              push;
  logic [PREG_W-1:0] new_preg;

  // Reset images: identity RAT, free list seeded with every preg above the architectural range.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_AREGS; gi++) begin : g_rat_rst
      assign rat_rst[gi] = PREG_W'(gi);
    end
    for (gi = 0; gi < FL_DEPTH; gi++) begin : g_fl_rst
      assign fl_rst[gi] = PREG_W'(NUM_AREGS + gi);
    end
  endgenerate

  assign need_alloc = in_has_dest && (in_dr != '0);
  assign fl_empty   = (count_q == '0);
  assign fl_full    = (count_q == CNT_W'(FL_DEPTH));

`ifdef RENAME_FREE_BYPASS_EN
  assign bypass_ok = fl_empty && need_alloc && ret_valid && (ret_preg != '0);
`else
  assign bypass_ok = 1'b0;
`endif

  // Ready never looks at in_valid so decode can use it to decide whether to present.
  assign in_ready    = (!out_valid_q || out_ready) && (!need_alloc || !fl_empty || bypass_ok);
  assign accept      = in_valid && in_ready;
  assign take_bypass = accept && bypass_ok;
  assign pop         = accept && need_alloc && !bypass_ok;
  assign push        = ret_valid && (ret_preg != '0) && !take_bypass && !fl_full;
  assign new_preg    = bypass_ok ? ret_preg : fl_q[head_q];

  always_comb begin
    rat_d = rat_q;
    if (accept && need_alloc) begin
      rat_d[in_dr] = new_preg;
    end
  end

  always_comb begin
    fl_d = fl_q;
    if (push) begin
      fl_d[tail_q] = ret_preg;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = (head_q == PTR_W'(FL_DEPTH - 1)) ? '0 : head_q + 1'b1;
    end
    if (push) begin
      tail_d = (tail_q == PTR_W'(FL_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Sources read the RAT before this instruction's own destination write lands.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_sr1_p_d    = out_sr1_p_q;
    out_sr2_p_d    = out_sr2_p_q;
    out_dr_p_d     = out_dr_p_q;
    out_old_dr_p_d = out_old_dr_p_q;
    out_has_dest_d = out_has_dest_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sr1_p_d = rat_q[in_sr1];
      out_sr2_p_d = rat_q[in_sr2];
      if (need_alloc) begin
        out_dr_p_d     = new_preg;
        out_old_dr_p_d = rat_q[in_dr];
        out_has_dest_d = 1'b1;
      end else begin
        out_dr_p_d     = rat_q[in_dr];
        out_old_dr_p_d = '0;
        out_has_dest_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rat_q          <= rat_rst;
      fl_q           <= fl_rst;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= CNT_W'(FL_DEPTH);
      out_valid_q    <= 1'b0;
      out_sr1_p_q    <= '0;
      out_sr2_p_q    <= '0;
      out_dr_p_q     <= '0;
      out_old_dr_p_q <= '0;
      out_has_dest_q <= 1'b0;
    end else begin
      rat_q          <= rat_d;
      fl_q           <= fl_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_sr1_p_q    <= out_sr1_p_d;
      out_sr2_p_q    <= out_sr2_p_d;
      out_dr_p_q     <= out_dr_p_d;
      out_old_dr_p_q <= out_old_dr_p_d;
      out_has_dest_q <= out_has_dest_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sr1_p    = out_sr1_p_q;
  assign out_sr2_p    = out_sr2_p_q;
  assign out_dr_p     = out_dr_p_q;
  assign out_old_dr_p = out_old_dr_p_q;
  assign out_has_dest = out_has_dest_q;
  assign free_count   = count_q;

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: queue/array reference model checked every negedge, plus hand-computed literal checks.
module tb_rename_unit;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int FD = NP - NA;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid, in_ready, in_has_dest;
  logic [4:0] in_sr1, in_sr2, in_dr;
  logic       out_valid, out_ready, out_has_dest;
  logic [5:0] out_sr1_p, out_sr2_p, out_dr_p, out_old_dr_p;
  logic       ret_valid;
  logic [5:0] ret_preg;
  logic [5:0] free_count;

  always #5 clk = ~clk;

  rename_unit #(.NUM_AREGS(NA), .NUM_PREGS(NP)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_has_dest(in_has_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sr1_p(out_sr1_p), .out_sr2_p(out_sr2_p), .out_dr_p(out_dr_p),
    .out_old_dr_p(out_old_dr_p), .out_has_dest(out_has_dest),
    .ret_valid(ret_valid), .ret_preg(ret_preg), .free_count(free_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mapping table array, free list as a plain FIFO queue.
  int  m_rat [NA];
  int  m_fl [$];
  bit  m_ov, m_hd;
  int  m_sr1, m_sr2, m_dr, m_old;

  function automatic bit m_need();
    return in_has_dest && (in_dr != 0);
  endfunction

  function automatic bit m_bypass();
`ifdef RENAME_FREE_BYPASS_EN
    return (m_fl.size() == 0) && m_need() && ret_valid && (ret_preg != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (!m_ov || out_ready) && (!m_need() || m_fl.size() != 0 || m_bypass());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_rat[i] = i;
    m_fl.delete();
    for (int i = 0; i < FD; i++) m_fl.push_back(NA + i);
    m_ov = 0; m_hd = 0; m_sr1 = 0; m_sr2 = 0; m_dr = 0; m_old = 0;
  endtask

  task automatic model_step();
    bit need, byp, acc;
    int s0, np;
    need = m_need();
    byp  = m_bypass();
    acc  = in_valid && m_ready();
    s0   = m_fl.size();
    if (acc) begin
      m_sr1 = m_rat[in_sr1];
      m_sr2 = m_rat[in_sr2];
      if (need) begin
        np = byp ? int'(ret_preg) : m_fl.pop_front();
        m_old = m_rat[in_dr];
        m_dr  = np;
        m_rat[in_dr] = np;
        m_hd  = 1;
      end else begin
        m_dr  = m_rat[in_dr];
        m_old = 0;
        m_hd  = 0;
      end
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (ret_valid && ret_preg != 0 && !(acc && byp) && s0 < FD) m_fl.push_back(int'(ret_preg));
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", int'(in_ready), int'(m_ready()));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("free_count", int'(free_count), m_fl.size());
      if (m_ov) begin
        chk("out_sr1_p", int'(out_sr1_p), m_sr1);
        chk("out_sr2_p", int'(out_sr2_p), m_sr2);
        chk("out_dr_p", int'(out_dr_p), m_dr);
        chk("out_old_dr_p", int'(out_old_dr_p), m_old);
        chk("out_has_dest", int'(out_has_dest), int'(m_hd));
      end
    end
  end

  task automatic present(bit iv, int s1, int s2, int d, bit hd, bit ordy, bit rv, int rp);
    in_valid    = iv;
    in_sr1      = 5'(s1);
    in_sr2      = 5'(s2);
    in_dr       = 5'(d);
    in_has_dest = hd;
    out_ready   = ordy;
    ret_valid   = rv;
    ret_preg    = 6'(rp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(bit iv, int s1, int s2, int d, bit hd, bit ordy, bit rv, int rp);
    present(iv, s1, s2, d, hd, ordy, rv, rp);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    present(0, 0, 0, 0, 0, 1, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_dr_p", int'(out_dr_p), 0);
    rstn = 1'b1;

    // Free-list full: retire is dropped
    drive(0, 0, 0, 0, 0, 1, 1, 50);
    chk("full_push_drop", int'(free_count), 32);

    // First rename and back-to-back dependency
    drive(1, 5, 3, 5, 1, 1, 0, 0);
    chk("t1_sr1", int'(out_sr1_p), 5);
    chk("t1_sr2", int'(out_sr2_p), 3);
    chk("t1_dr", int'(out_dr_p), 32);
    chk("t1_old", int'(out_old_dr_p), 5);
    chk("t1_fc", int'(free_count), 31);
    drive(1, 5, 0, 5, 1, 1, 0, 0);
    chk("t2_sr1", int'(out_sr1_p), 32);
    chk("t2_dr", int'(out_dr_p), 33);
    chk("t2_old", int'(out_old_dr_p), 32);

    // Drain the free list: dr 1..30 receive pregs 34..63
    for (int i = 0; i < 30; i++) drive(1, i % 32, (i + 1) % 32, 1 + i, 1, 1, 0, 0);
    chk("empty_fc", int'(free_count), 0);
    present(1, 1, 2, 7, 1, 1, 0, 0);
    #1;
    chk("empty_in_ready", int'(in_ready), 0);
    tick();
    chk("empty_out_valid", int'(out_valid), 0);
    drive(1, 2, 3, 7, 0, 1, 0, 0);
    chk("store_dr", int'(out_dr_p), 40);
    chk("store_old", int'(out_old_dr_p), 0);
    chk("store_has_dest", int'(out_has_dest), 0);

    // Free at count 0 racing an allocation
    present(1, 4, 0, 9, 1, 1, 1, 40);
    #1;
`ifdef RENAME_FREE_BYPASS_EN
    chk("race_in_ready", int'(in_ready), 1);
    tick();
    chk("bypass_dr", int'(out_dr_p), 40);
    chk("bypass_fc", int'(free_count), 0);
`else
    chk("race_in_ready", int'(in_ready), 0);
    tick();
    chk("ret_fc", int'(free_count), 1);
    drive(1, 4, 0, 9, 1, 1, 0, 0);
    chk("wrap_dr", int'(out_dr_p), 40);
    chk("wrap_fc", int'(free_count), 0);
`endif

    for (int p = 1; p <= 6; p++) drive(0, 0, 0, 0, 0, 1, 1, p);
    chk("refill_fc", int'(free_count), 6);

    // Back-pressure hold
    drive(1, 0, 0, 11, 1, 1, 0, 0);
    chk("hold_dr0", int'(out_dr_p), 1);
    for (int k = 0; k < 3; k++) begin
      present(1, 11, 0, 12, 1, 0, 0, 0);
      #1;
      chk("hold_in_ready", int'(in_ready), 0);
      tick();
      chk("hold_dr", int'(out_dr_p), 1);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_fc", int'(free_count), 5);
    end
    drive(1, 11, 0, 12, 1, 1, 0, 0);
    chk("release_sr1", int'(out_sr1_p), 1);
    chk("release_dr", int'(out_dr_p), 2);
    chk("release_fc", int'(free_count), 4);

    // Mixed traffic, model-checked
    for (int i = 0; i < 40; i++)
      drive(i % 3 != 0, i % 32, (i * 5) % 32, (i * 7) % 32, i % 4 != 3, i % 5 != 1, i % 2 == 0, (i * 11) % 64);

    // Asynchronous reset mid-stream
    drive(1, 3, 4, 6, 0, 1, 0, 0);
    chk("pre_rst_valid", int'(out_valid), 1);
    present(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_fc", int'(free_count), 32);
    chk("mid_rst_dr", int'(out_dr_p), 0);
    model_reset();
    #2;
    rstn = 1'b1;
    drive(1, 5, 11, 0, 1, 1, 0, 0);
    chk("x0_sr1", int'(out_sr1_p), 5);
    chk("x0_sr2", int'(out_sr2_p), 11);
    chk("x0_dr", int'(out_dr_p), 0);
    chk("x0_has_dest", int'(out_has_dest), 0);
    chk("x0_fc", int'(free_count), 32);
    drive(1, 5, 0, 5, 1, 1, 0, 0);
    chk("post_rst_dr", int'(out_dr_p), 32);
    chk("post_rst_old", int'(out_old_dr_p), 5);

    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
